// File: rtl/mem_responder.sv
// Multi-cycle memory slave: unified word RAM answering fetch, load and
// store requests with lane select, extension and alignment checks.
module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_fetch_i,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        fetch_q, write_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q;
  logic        accept, commit;

  logic [31:0] mem_q [2**ADDR_WIDTH];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    accept       = 1'b0;
    commit       = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          accept = 1'b1;
          cnt_d  = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: begin
        resp_valid_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY==1 the commit edge is the accept edge, so use live inputs.
  logic        op_fetch, op_write, op_uns, wr_e, op_err;
  logic [1:0]  op_size, size_e;
  logic [31:0] op_addr, op_wdata;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0] rd_word, wd;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [3:0]  be;

  assign op_fetch = (state_q == IDLE) ? req_fetch_i    : fetch_q;
  assign op_write = (state_q == IDLE) ? req_write_i    : write_q;
  assign op_uns   = (state_q == IDLE) ? req_unsigned_i : uns_q;
  assign op_size  = (state_q == IDLE) ? req_size_i     : size_q;
  assign op_addr  = (state_q == IDLE) ? req_addr_i     : addr_q;
  assign op_wdata = (state_q == IDLE) ? req_wdata_i    : wdata_q;

  assign size_e  = op_fetch ? 2'b10 : op_size;
  assign wr_e    = op_write & ~op_fetch;
  assign idx     = op_addr[ADDR_WIDTH+1:2];
  assign rd_word = mem_q[idx];
  assign op_err  = (size_e == 2'b11)
                 | ((size_e == 2'b01) & op_addr[0])
                 | ((size_e == 2'b10) & (|op_addr[1:0]))
                 | (|op_addr[31:ADDR_WIDTH+2]);

  always_comb begin
    unique case (op_addr[1:0])
      2'd0: bsel = rd_word[7:0];
      2'd1: bsel = rd_word[15:8];
      2'd2: bsel = rd_word[23:16];
      default: bsel = rd_word[31:24];
    endcase
    hsel = op_addr[1] ? rd_word[31:16] : rd_word[15:0];
  end

  always_comb begin
    rdata_d = 32'd0;
    be      = 4'b0000;
    wd      = op_wdata;
    unique case (size_e)
      2'b00: begin
        rdata_d = {{24{bsel[7] & ~op_uns}}, bsel};
        be      = 4'b0001 << op_addr[1:0];
        wd      = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        rdata_d = {{16{hsel[15] & ~op_uns}}, hsel};
        be      = op_addr[1] ? 4'b1100 : 4'b0011;
        wd      = {2{op_wdata[15:0]}};
      end
      2'b10: begin
        rdata_d = rd_word;
        be      = 4'b1111;
      end
      default: begin
        rdata_d = 32'd0;
        be      = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      fetch_q <= 1'b0;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        fetch_q <= req_fetch_i;
        write_q <= req_write_i;
        uns_q   <= req_unsigned_i;
        size_q  <= req_size_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
      end
      if (commit) begin
        rdata_q <= (op_err | wr_e) ? 32'd0 : rdata_d;
        err_q   <= op_err;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && commit && wr_e && !op_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table plus handshake,
// back-to-back and reset-abort sequences.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_fetch = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_fetch_i    (req_fetch),
    .req_write_i    (req_write),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .resp_valid_o   (resp_valid),
    .resp_rdata_o   (resp_rdata),
    .resp_err_o     (resp_err)
  );

  typedef struct {
    logic        fetch;
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  function automatic vec_t mk(logic f, logic w, logic [1:0] s, logic u,
                              logic [31:0] a, logic [31:0] d,
                              logic [31:0] er, logic ee);
    vec_t v;
    v.fetch = f; v.write = w; v.size = s; v.uns = u;
    v.addr = a; v.wdata = d; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_fetch    = v.fetch;
    req_write    = v.write;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
  endtask

  task automatic run(input vec_t v, input string name);
    int lat;
    int w;
    @(negedge clk);
    drive(v);
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      chk({name, "_ready_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    chk({name, "_lat"}, 32'(lat), 32'd2);
    chk({name, "_rdata"}, resp_rdata, v.exp_rdata);
    chk({name, "_err"}, 32'(resp_err), 32'(v.exp_err));
  endtask

  logic exp_rdy [7];
  logic exp_vld [7];
  int   pulses;

  initial begin
    tbl[0]  = mk(0,1,2'b10,0,32'h10,  32'hDEADBEEF,32'h0,       0);
    tbl[1]  = mk(0,0,2'b10,0,32'h10,  32'h0,       32'hDEADBEEF,0);
    tbl[2]  = mk(0,1,2'b10,0,32'h20,  32'h0,       32'h0,       0);
    tbl[3]  = mk(0,1,2'b00,0,32'h21,  32'h12345680,32'h0,       0);
    tbl[4]  = mk(0,0,2'b00,0,32'h21,  32'h0,       32'hFFFFFF80,0);
    tbl[5]  = mk(0,0,2'b00,1,32'h21,  32'h0,       32'h00000080,0);
    tbl[6]  = mk(0,0,2'b10,0,32'h20,  32'h0,       32'h00008000,0);
    tbl[7]  = mk(0,1,2'b10,0,32'h30,  32'h5555ABCD,32'h0,       0);
    tbl[8]  = mk(0,1,2'b01,0,32'h32,  32'hCAFE1234,32'h0,       0);
    tbl[9]  = mk(0,0,2'b01,0,32'h32,  32'h0,       32'h00001234,0);
    tbl[10] = mk(0,0,2'b10,0,32'h30,  32'h0,       32'h1234ABCD,0);
    tbl[11] = mk(0,0,2'b01,0,32'h30,  32'h0,       32'hFFFFABCD,0);
    tbl[12] = mk(0,0,2'b01,1,32'h30,  32'h0,       32'h0000ABCD,0);
    tbl[13] = mk(0,1,2'b10,0,32'h04,  32'h0BADF00D,32'h0,       0);
    tbl[14] = mk(0,0,2'b01,0,32'h05,  32'h0,       32'h0,       1);
    tbl[15] = mk(0,1,2'b10,0,32'h06,  32'hFFFFFFFF,32'h0,       1);
    tbl[16] = mk(0,0,2'b10,0,32'h04,  32'h0,       32'h0BADF00D,0);
    tbl[17] = mk(0,0,2'b11,0,32'h04,  32'h0,       32'h0,       1);
    tbl[18] = mk(0,0,2'b10,0,32'h1000,32'h0,       32'h0,       1);
    tbl[19] = mk(1,1,2'b00,1,32'h10,  32'h0,       32'hDEADBEEF,0);
    tbl[20] = mk(0,0,2'b10,0,32'h10,  32'h0,       32'hDEADBEEF,0);
    tbl[21] = mk(0,0,2'b00,0,32'h13,  32'h0,       32'hFFFFFFDE,0);
    tbl[22] = mk(0,1,2'b00,0,32'hFFF, 32'h000000A5,32'h0,       0);
    tbl[23] = mk(0,0,2'b00,1,32'hFFF, 32'h0,       32'h000000A5,0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run(tbl[i], $sformatf("vec%0d", i));

    // back-to-back with req_valid held high
    exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_vld = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    drive(mk(0,0,2'b10,0,32'h10,32'h0,32'h0,0));
    req_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("b2b_ready%0d", i), 32'(req_ready), 32'(exp_rdy[i]));
      chk($sformatf("b2b_valid%0d", i), 32'(resp_valid), 32'(exp_vld[i]));
      if (i == 1) drive(mk(0,0,2'b10,0,32'h20,32'h0,32'h0,0));
      if (i == 2) chk("b2b_rdataA", resp_rdata, 32'hDEADBEEF);
      if (i == 5) begin
        chk("b2b_rdataB", resp_rdata, 32'h00008000);
        req_valid = 1'b0;
      end
    end

    // reset during WAIT of a store aborts it
    run(mk(0,1,2'b10,0,32'h40,32'h11111111,32'h0,0), "pre40");
    @(negedge clk);
    drive(mk(0,1,2'b10,0,32'h40,32'h22222222,32'h0,0));
    req_valid = 1'b1;
    @(negedge clk);
    chk("abort_wait_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_valid", 32'(resp_valid), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    chk("abort_no_resp", 32'(pulses), 32'd0);
    run(mk(0,0,2'b10,0,32'h40,32'h0,32'h11111111,0), "post40");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
